// File: rtl/generic_fifo_sc_b_core.sv
`default_nettype none
// ============================================================================
// Module   : generic_fifo_sc_b_core
// Purpose  : single-clock show-ahead FIFO, exact/almost flags and coarse level
// Revision : 1.0
// ============================================================================
module generic_fifo_sc_b_core #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int N  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          we,
  output logic [DW-1:0] dout,
  input  logic          re,
  output logic          full,
  output logic          empty,
  output logic          full_r,
  output logic          empty_r,
  output logic          full_n,
  output logic          empty_n,
  output logic          full_n_r,
  output logic          empty_n_r,
  output logic [1:0]    level
);

  localparam int          c_DEPTH     = 1 << AW;
  localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(c_DEPTH);
  localparam logic [AW:0] c_FULL_N    = (AW+1)'(c_DEPTH - N);
  localparam logic [AW:0] c_EMPTY_N   = (AW+1)'(N);

  logic [DW-1:0] r_mem [c_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign w_wr = we & ~full;
  assign w_rd = re & ~empty;

  // Storage has no reset; clr flushes only the bookkeeping.
  always_ff @(posedge clk) begin
    if (w_wr && !clr) begin
      r_mem[r_wp] <= din;
    end
  end

  assign dout = r_mem[r_rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign full    = (r_cnt == c_DEPTH_CNT);
  assign empty   = (r_cnt == '0);
  assign full_n  = (r_cnt >= c_FULL_N);
  assign empty_n = (r_cnt <= c_EMPTY_N);
  assign level   = full ? 2'b11 : r_cnt[AW-1:AW-2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      full_n_r  <= 1'b0;
      empty_n_r <= 1'b1;
    end else if (clr) begin
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      full_n_r  <= 1'b0;
      empty_n_r <= 1'b1;
    end else begin
      full_r    <= full;
      empty_r   <= empty;
      full_n_r  <= full_n;
      empty_n_r <= empty_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_generic_fifo_sc_b_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_generic_fifo_sc_b_core
// Purpose  : directed self-checking bench for generic_fifo_sc_b_core
// Revision : 1.0
// ============================================================================
module tb_generic_fifo_sc_b_core;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [15:0] din;
  logic        we;
  logic [15:0] dout;
  logic        re;
  logic        full, empty, full_r, empty_r;
  logic        full_n, empty_n, full_n_r, empty_n_r;
  logic [1:0]  level;

  generic_fifo_sc_b_core #(.DW(16), .AW(9), .N(32)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .din       (din),
    .we        (we),
    .dout      (dout),
    .re        (re),
    .full      (full),
    .empty     (empty),
    .full_r    (full_r),
    .empty_r   (empty_r),
    .full_n    (full_n),
    .empty_n   (empty_n),
    .full_n_r  (full_n_r),
    .empty_n_r (empty_n_r),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q[$];
  bit x_full_r, x_empty_r, x_full_n_r, x_empty_n_r;

  typedef struct {
    logic        c;
    logic        w;
    logic        r;
    logic [15:0] d;
    logic        e_empty;
    logic        e_full;
    logic [1:0]  e_level;
    logic        chk_dout;
    logic [15:0] e_dout;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lvl(input int sz);
    if (sz == 512)     return 3;
    else if (sz < 128) return 0;
    else if (sz < 256) return 1;
    else if (sz < 384) return 2;
    else               return 3;
  endfunction

  task automatic cycle(input logic c, input logic w, input logic r, input logic [15:0] d);
    int sz;
    bit pf, pe, pfn, pen;
    sz  = q.size();
    pf  = (sz == 512);
    pe  = (sz == 0);
    pfn = (sz >= 480);
    pen = (sz <= 32);
    clr = c; we = w; re = r; din = d;
    @(posedge clk);
    #1;
    if (c) begin
      q.delete();
      x_full_r = 0; x_empty_r = 1; x_full_n_r = 0; x_empty_n_r = 1;
    end else begin
      if (r && !pe) void'(q.pop_front());
      if (w && !pf) q.push_back(d);
      x_full_r = pf; x_empty_r = pe; x_full_n_r = pfn; x_empty_n_r = pen;
    end
    clr = 0; we = 0; re = 0;
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = q.size();
    chk({tag, "_empty"},     int'(empty),     int'(sz == 0));
    chk({tag, "_full"},      int'(full),      int'(sz == 512));
    chk({tag, "_full_n"},    int'(full_n),    int'(sz >= 480));
    chk({tag, "_empty_n"},   int'(empty_n),   int'(sz <= 32));
    chk({tag, "_level"},     int'(level),     lvl(sz));
    chk({tag, "_full_r"},    int'(full_r),    int'(x_full_r));
    chk({tag, "_empty_r"},   int'(empty_r),   int'(x_empty_r));
    chk({tag, "_full_n_r"},  int'(full_n_r),  int'(x_full_n_r));
    chk({tag, "_empty_n_r"}, int'(empty_n_r), int'(x_empty_n_r));
    if (sz > 0) chk({tag, "_dout"}, int'(dout), int'(q[0]));
  endtask

  initial begin
    rst = 1; clr = 0; we = 0; re = 0; din = '0;
    x_full_r = 0; x_empty_r = 1; x_full_n_r = 0; x_empty_n_r = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset values
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_empty_r", int'(empty_r), 1);
    chk("rst_full_r", int'(full_r), 0);
    chk("rst_empty_n", int'(empty_n), 1);
    chk("rst_empty_n_r", int'(empty_n_r), 1);
    chk("rst_full_n", int'(full_n), 0);
    chk("rst_full_n_r", int'(full_n_r), 0);

    // Short directed table: c w r din | empty full level chk_dout dout
    tbl[0] = '{0, 1, 0, 16'h0001, 0, 0, 2'd0, 1, 16'h0001};
    tbl[1] = '{0, 1, 0, 16'h0002, 0, 0, 2'd0, 1, 16'h0001};
    tbl[2] = '{0, 1, 1, 16'h0003, 0, 0, 2'd0, 1, 16'h0002};
    tbl[3] = '{0, 0, 1, 16'h0000, 0, 0, 2'd0, 1, 16'h0003};
    tbl[4] = '{0, 0, 1, 16'h0000, 1, 0, 2'd0, 0, 16'h0000};
    tbl[5] = '{0, 0, 1, 16'h0000, 1, 0, 2'd0, 0, 16'h0000};
    tbl[6] = '{0, 1, 1, 16'h0055, 0, 0, 2'd0, 1, 16'h0055};
    tbl[7] = '{0, 1, 0, 16'h0066, 0, 0, 2'd0, 1, 16'h0055};
    tbl[8] = '{1, 1, 1, 16'h0077, 1, 0, 2'd0, 0, 16'h0000};
    tbl[9] = '{0, 0, 1, 16'h0000, 1, 0, 2'd0, 0, 16'h0000};
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].d);
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(tbl[i].e_empty));
      chk($sformatf("vec%0d_full", i), int'(full), int'(tbl[i].e_full));
      chk($sformatf("vec%0d_level", i), int'(level), int'(tbl[i].e_level));
      if (tbl[i].chk_dout) chk($sformatf("vec%0d_dout", i), int'(dout), int'(tbl[i].e_dout));
      check_state($sformatf("vec%0d", i));
    end

    // Fill 5 then clear
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 16'(16'h0A00 + i));
    chk("fill5_empty", int'(empty), 0);
    cycle(1, 0, 0, 16'h0);
    chk("clr_empty", int'(empty), 1);
    chk("clr_level", int'(level), 0);
    chk("clr_empty_r", int'(empty_r), 1);
    check_state("clr");

    // FWFT ordering
    for (int i = 1; i <= 16; i++) cycle(0, 1, 0, 16'(i));
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("fwft_dout%0d", i), int'(dout), i);
      cycle(0, 0, 1, 16'h0);
    end
    chk("fwft_empty", int'(empty), 1);
    chk("fwft_empty_r_lag", int'(empty_r), 0);
    cycle(0, 0, 0, 16'h0);
    chk("fwft_empty_r", int'(empty_r), 1);

    // Fill to full, with almost-flag and level boundaries
    cycle(1, 0, 0, 16'h0);
    for (int i = 0; i < 512; i++) begin
      cycle(0, 1, 0, 16'(i));
      case (i + 1)
        32:  chk("cnt32_empty_n", int'(empty_n), 1);
        33:  chk("cnt33_empty_n", int'(empty_n), 0);
        128: chk("cnt128_level", int'(level), 1);
        256: chk("cnt256_level", int'(level), 2);
        479: chk("cnt479_full_n", int'(full_n), 0);
        480: chk("cnt480_full_n", int'(full_n), 1);
        511: chk("cnt511_full", int'(full), 0);
        default: ;
      endcase
      check_state("fill");
    end
    chk("full_full", int'(full), 1);
    chk("full_level", int'(level), 3);
    chk("full_full_r_lag", int'(full_r), 0);
    cycle(0, 1, 0, 16'hDEAD);
    chk("drop_full", int'(full), 1);
    chk("drop_full_r", int'(full_r), 1);
    check_state("drop");
    for (int i = 0; i < 512; i++) begin
      chk($sformatf("drain%0d_dout", i), int'(dout), i);
      cycle(0, 0, 1, 16'h0);
    end
    chk("drain_empty", int'(empty), 1);
    check_state("drain");

    // Simultaneous read/write at count 10 across pointer wrap
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 16'(16'h0100 + i));
    for (int k = 0; k < 600; k++) begin
      chk("simul_dout", int'(dout), 16'h0100 + k);
      cycle(0, 1, 1, 16'(16'h0100 + 10 + k));
      chk("simul_empty", int'(empty), 0);
      chk("simul_level", int'(level), 0);
      check_state("simul");
    end

    // Async reset mid-transfer
    cycle(0, 1, 0, 16'h1234);
    #2 rst = 1;
    #1;
    chk("arst_empty", int'(empty), 1);
    chk("arst_empty_n", int'(empty_n), 1);
    chk("arst_empty_r", int'(empty_r), 1);
    chk("arst_level", int'(level), 0);
    chk("arst_full_r", int'(full_r), 0);
    #1 rst = 0;
    q.delete();
    x_full_r = 0; x_empty_r = 1; x_full_n_r = 0; x_empty_n_r = 1;
    cycle(0, 1, 0, 16'hBEEF);
    chk("post_arst_dout", int'(dout), 16'hBEEF);
    check_state("post_arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/generic_fifo_sc_b_core.md
Name: generic_fifo_sc_b_core

Overview:
Single-clock synchronous FIFO with show-ahead (first-word-fall-through) output. It provides exact and almost full/empty flags, their one-cycle-delayed copies, and a coarse 2-bit fill level. In the neuron status memory it buffers synaptic weight words read from the weight RAM. The learning logic later drains it, and it is flushed at the start of each time step via clr.

Parameters:
dw, 8, data word width in bits
aw, 8, address width; depth DEPTH = 2^aw entries (aw >= 2)
n, 32, almost-full/almost-empty margin in entries (1 <= n < 2^aw)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
clr  in  1  synchronous clear/flush, active-high
din  in  dw  write data
we  in  1  write enable
dout  out  dw  data at head of queue (show-ahead)
re  in  1  read enable (pops head)
full  out  1  count == DEPTH
empty  out  1  count == 0
full_r  out  1  full delayed one clk
empty_r  out  1  empty delayed one clk
full_n  out  1  almost full: count >= DEPTH-n
empty_n  out  1  almost empty: count <= n
full_n_r  out  1  full_n delayed one clk
empty_n_r  out  1  empty_n delayed one clk
level  out  2  coarse fill level

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- State:
  - storage array of DEPTH x dw (no reset on contents)
  - write pointer wp and read pointer rp, aw bits each, wrapping modulo DEPTH
  - registered count, aw+1 bits
- Reset (rst=1, async):
  - wp=rp=count=0
  - empty=1, empty_r=1, empty_n=1, empty_n_r=1
  - full=0, full_r=0, full_n=0, full_n_r=0
  - level=00; dout undefined (content of mem[0])
- clr=1 at clock edge:
  - same pointer/count/flag values as reset, including the _r flags
  - overrides we/re in that cycle
  - storage contents untouched
- Effective write: wr = we & ~full. Effective read: rd = re & ~empty.
  - Write to a full FIFO is ignored; read of an empty FIFO is ignored (no pointer move, no error flag).
- On wr: mem[wp] <= din; wp <= wp+1.
- On rd: rp <= rp+1.
- Count update:
  - wr only: +1
  - rd only: -1
  - both: unchanged (legal at any fill level between 1 and DEPTH-1; when full, re frees a slot but the write is still dropped; when empty, the write is accepted and the read is dropped).
- dout = mem[rp], combinational read of the storage array.
  - A word written into an empty FIFO appears on dout in the cycle after the write edge, coincident with empty falling.
  - dout is don't-care while empty.
- Flags: full, empty, full_n, empty_n decode combinationally from the registered count, so they change right after the clock edge that updates count. The _r variants are plain flops of the corresponding flag (one extra cycle of latency).
- level:
  - 11 when full, else count[aw-1:aw-2]
  - i.e. 00 for < DEPTH/4, 01 for < DEPTH/2, 10 for < 3·DEPTH/4, 11 otherwise.
- Pointer wrap: wp/rp roll from DEPTH-1 to 0 with no gap; data order is preserved across wrap.

Test Plan:
- Reset/clr (dw=16, aw=9, n=32): pulse rst -> empty=1, full=0, level=00, all _r flags at reset values. Fill 5 words, then clr=1 for one cycle -> next cycle empty=1, count 0, level=00.
- FWFT ordering: write 0x0001..0x0010 on consecutive cycles, then assert re for 16 cycles -> dout shows 0x0001 first and increments each pop; empty=1 after the 16th pop; empty_r follows one cycle later.
- Fill to full: write 512 words -> full=1 after the 512th write edge and level=11. A 513th write with data 0xDEAD is dropped, and readback never shows 0xDEAD. full_r asserts one cycle after full.
- Almost flags: at count=32 -> empty_n=1; at count=33 -> empty_n=0; at count=479 -> full_n=0; at count=480 -> full_n=1. level is 01 at count 128 and 10 at count 256.
- Simultaneous re & we at count=10 for 600 cycles -> count stays 10, pointers wrap, dout sequence continuous and in order.
- Edge cases: re on empty FIFO -> no change; write plus read on empty -> count becomes 1, dout equals written word. Async rst asserted mid-transfer -> flags reset immediately without waiting for a clock.
